// File: rtl/ntcrack_host_ctrl.sv
// NT-hash cracker host controller: pin sync, hash assembly, core start,
// first-match arbitration and byte-per-handshake password readback.
module ntcrack_host_ctrl #(
  parameter int NUM_CORES      = 4,
  parameter int HASH_BYTES     = 16,
  parameter int PW_MAX_BYTES   = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int BLINK_DIV_LOG2 = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      new_hash_byte,
  input  logic                            store_hash_byte,
  input  logic                            go,
  output logic [8*HASH_BYTES-1:0]         hash,
  output logic [NUM_CORES-1:0]            core_start,
  input  logic [NUM_CORES-1:0]            core_match,
  input  logic [NUM_CORES-1:0]            core_done,
  input  logic [NUM_CORES*8*PW_MAX_BYTES-1:0] core_password,
  output logic                            match_found,
  output logic                            your_turn,
  output logic [7:0]                      password_byte,
  output logic                            blinky_led,
  output logic                            busy
);

  localparam int PW_W  = 8 * PW_MAX_BYTES;
  localparam int CNT_W = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
  localparam int IDX_W = (PW_MAX_BYTES > 1) ? $clog2(PW_MAX_BYTES) : 1;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    EMIT,
    EXHAUSTED
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0]      store_sync;
  logic [SYNC_STAGES-1:0]      go_sync;
  logic [SYNC_STAGES-1:0][7:0] byte_sync;
  logic                        store_prev;
  logic                        go_prev;
  logic                        store_s;
  logic                        go_s;
  logic [7:0]                  byte_s;
  logic                        store_evt;
  logic                        go_evt;

  logic [HASH_BYTES-1:0][7:0]   hash_r;
  logic [CNT_W-1:0]             cnt;
  logic                         full;
  logic [PW_MAX_BYTES-1:0][7:0] pw_lat;
  logic [IDX_W-1:0]             emit_idx;
  logic [BLINK_DIV_LOG2-1:0]    div;
  logic [PW_W-1:0]              match_pw;
  logic [7:0]                   cur_byte;
  logic                         emit_last;
  logic                         any_match;

  assign store_s   = store_sync[SYNC_STAGES-1];
  assign go_s      = go_sync[SYNC_STAGES-1];
  assign byte_s    = byte_sync[SYNC_STAGES-1];
  assign store_evt = store_s & ~store_prev;
  assign go_evt    = go_s & ~go_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_sync <= '0;
      go_sync    <= '0;
      byte_sync  <= '0;
      store_prev <= 1'b0;
      go_prev    <= 1'b0;
      div        <= '0;
    end else begin
      store_sync <= {store_sync[SYNC_STAGES-2:0], store_hash_byte};
      go_sync    <= {go_sync[SYNC_STAGES-2:0], go};
      byte_sync  <= {byte_sync[SYNC_STAGES-2:0], new_hash_byte};
      store_prev <= store_s;
      go_prev    <= go_s;
      div        <= div + 1'b1;
    end
  end

  // Downward scan leaves the lowest-index matching core selected.
  always_comb begin
    match_pw = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_match[i]) match_pw = core_password[i*PW_W +: PW_W];
    end
  end

  assign any_match = |core_match;
  assign cur_byte  = pw_lat[emit_idx];
  assign emit_last = (cur_byte == 8'h00) ||
                     (emit_idx == IDX_W'(PW_MAX_BYTES - 1));

  always_comb begin
    state_d = state;
    unique case (state)
      LOAD: begin
        if (go_evt && !store_evt && full) state_d = RUN;
      end
      RUN: begin
        if (any_match) state_d = EMIT;
        else if (&core_done) state_d = EXHAUSTED;
      end
      EMIT: begin
        if (go_evt && emit_last) state_d = LOAD;
      end
      EXHAUSTED: begin
        if (go_evt) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      core_start  <= '0;
      hash_r      <= '0;
      cnt         <= '0;
      full        <= 1'b0;
      pw_lat      <= '0;
      emit_idx    <= '0;
      match_found <= 1'b0;
    end else begin
      state      <= state_d;
      core_start <= {NUM_CORES{(state == LOAD) && (state_d == RUN)}};
      unique case (state)
        LOAD: begin
          if (store_evt) begin
            hash_r[cnt] <= byte_s;
            if (cnt == CNT_W'(HASH_BYTES - 1)) begin
              cnt  <= '0;
              full <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (any_match) begin
            pw_lat      <= match_pw;
            match_found <= 1'b1;
            emit_idx    <= '0;
          end
        end
        EMIT: begin
          if (go_evt) begin
            if (emit_last) begin
              match_found <= 1'b0;
              cnt         <= '0;
              full        <= 1'b0;
            end else begin
              emit_idx <= emit_idx + 1'b1;
            end
          end
        end
        EXHAUSTED: begin
          if (go_evt) begin
            match_found <= 1'b0;
            cnt         <= '0;
            full        <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hash          = hash_r;
  assign busy          = (state == RUN);
  assign your_turn     = (state != RUN);
  assign password_byte = (state == EMIT) ? cur_byte : 8'h00;
  assign blinky_led    = (state == RUN)  ? div[BLINK_DIV_LOG2-1] :
                         (state == EMIT);

endmodule

// File: tb/tb_ntcrack_host_ctrl.sv
// Directed bench for ntcrack_host_ctrl: hash load, start, match readback,
// exhaustion, simultaneous done/match and reset abort.
module tb_ntcrack_host_ctrl;

  localparam int NC = 4;
  localparam int HB = 16;
  localparam int PB = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        new_hash_byte = 8'h00;
  logic              store_hash_byte = 1'b0;
  logic              go = 1'b0;
  logic [8*HB-1:0]   hash;
  logic [NC-1:0]     core_start;
  logic [NC-1:0]     core_match = '0;
  logic [NC-1:0]     core_done = '0;
  logic [NC*8*PB-1:0] core_password = '0;
  logic              match_found;
  logic              your_turn;
  logic [7:0]        password_byte;
  logic              blinky_led;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int start_cycles = 0;
  logic bad_start = 1'b0;
  logic seen0, seen1;
  logic [127:0] exp_hash;

  ntcrack_host_ctrl #(
    .NUM_CORES(NC), .HASH_BYTES(HB), .PW_MAX_BYTES(PB),
    .SYNC_STAGES(2), .BLINK_DIV_LOG2(3)
  ) dut (
    .clk(clk), .rst(rst),
    .new_hash_byte(new_hash_byte),
    .store_hash_byte(store_hash_byte),
    .go(go), .hash(hash),
    .core_start(core_start),
    .core_match(core_match),
    .core_done(core_done),
    .core_password(core_password),
    .match_found(match_found),
    .your_turn(your_turn),
    .password_byte(password_byte),
    .blinky_led(blinky_led),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_start != '0) begin
      start_cycles <= start_cycles + 1;
      if (core_start != {NC{1'b1}}) bad_start <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic store(input logic [7:0] b);
    new_hash_byte = b;
    tick(1);
    store_hash_byte = 1'b1;
    tick(4);
    store_hash_byte = 1'b0;
    tick(4);
  endtask

  task automatic go_pulse();
    go = 1'b1;
    tick(4);
    go = 1'b0;
    tick(4);
  endtask

  task automatic set_pw(input int c, input int j, input logic [7:0] b);
    core_password[(c*PB+j)*8 +: 8] = b;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_your_turn", your_turn, 1);
    check("rst_busy", busy, 0);
    check("rst_match", match_found, 0);
    check("rst_pw", password_byte, 0);
    check("rst_hash", hash, 0);
    check("rst_blink", blinky_led, 0);
    check("rst_start", core_start, 0);

    for (int i = 0; i < 15; i++) store(8'(i));
    go_pulse();
    check("go15_nostart", start_cycles, 0);
    check("go15_busy", busy, 0);
    check("go15_turn", your_turn, 1);
    store(8'h0F);
    check("hash16", hash, 128'h0F0E0D0C0B0A09080706050403020100);
    store(8'hAA);
    check("hash17", hash, 128'h0F0E0D0C0B0A090807060504030201AA);
    go_pulse();
    check("start1", start_cycles, 1);
    check("run_busy", busy, 1);
    check("run_turn", your_turn, 0);
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (blinky_led) seen1 = 1'b1;
      else seen0 = 1'b0 | 1'b1;
    end
    check("run_blink_toggles", {seen0, seen1}, 2'b11);

    core_password = '0;
    set_pw(1, 0, "a"); set_pw(1, 1, "b"); set_pw(1, 2, "c");
    set_pw(3, 0, "x"); set_pw(3, 1, "y"); set_pw(3, 2, "z");
    core_match = 4'b1010;
    tick(2);
    core_match = '0;
    check("m_found", match_found, 1);
    check("m_byte0", password_byte, 8'h61);
    check("m_turn", your_turn, 1);
    check("m_busy", busy, 0);
    check("m_blink", blinky_led, 1);
    go_pulse();
    check("m_byte1", password_byte, 8'h62);
    go_pulse();
    check("m_byte2", password_byte, 8'h63);
    go_pulse();
    check("m_byte3", password_byte, 8'h00);
    check("m_still", match_found, 1);
    go_pulse();
    check("m_done_found", match_found, 0);
    check("m_done_pw", password_byte, 0);
    check("m_done_turn", your_turn, 1);
    check("m_done_blink", blinky_led, 0);
    check("hash_held", hash, 128'h0F0E0D0C0B0A090807060504030201AA);

    for (int i = 0; i < 16; i++) store(8'(8'h10 + i));
    check("hash2", hash, 128'h1F1E1D1C1B1A19181716151413121110);
    go_pulse();
    check("start2", start_cycles, 2);
    core_password = '0;
    for (int j = 0; j < PB; j++) set_pw(0, j, 8'(8'h41 + j));
    core_match = 4'b0001;
    tick(2);
    core_match = '0;
    for (int j = 0; j < PB; j++) begin
      check("full_byte", password_byte, 8'(8'h41 + j));
      go_pulse();
    end
    check("full_ret_found", match_found, 0);
    check("full_ret_turn", your_turn, 1);
    check("full_ret_pw", password_byte, 0);
    go_pulse();
    check("full_ret_nostart", start_cycles, 2);

    for (int i = 0; i < 16; i++) store(8'(8'h20 + i));
    go_pulse();
    check("start3", start_cycles, 3);
    core_done = 4'b1111;
    tick(2);
    check("ex_turn", your_turn, 1);
    check("ex_found", match_found, 0);
    check("ex_pw", password_byte, 0);
    check("ex_blink", blinky_led, 0);
    check("ex_busy", busy, 0);
    go_pulse();
    core_done = '0;
    go_pulse();
    check("ex_ret_nostart", start_cycles, 3);
    store(8'h77);
    check("ex_cnt0", hash[15:0], 16'h2177);

    for (int i = 1; i < 16; i++) store(8'(8'h30 + i));
    go_pulse();
    check("start4", start_cycles, 4);
    core_password = '0;
    set_pw(2, 0, "Q");
    set_pw(1, 0, "Z");
    core_done = 4'b1111;
    core_match = 4'b0100;
    tick(2);
    core_done = '0;
    core_match = '0;
    check("dm_found", match_found, 1);
    check("dm_byte0", password_byte, 8'h51);
    go_pulse();
    check("dm_byte1", password_byte, 8'h00);
    check("dm_turn", your_turn, 1);
    go_pulse();
    check("dm_ret", match_found, 0);

    for (int i = 0; i < 16; i++) store(8'(8'h40 + i));
    go_pulse();
    check("start5", start_cycles, 5);
    check("r_busy_pre", busy, 1);
    go = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    go = 1'b0;
    tick(10);
    check("r_nostart", start_cycles, 5);
    check("r_busy", busy, 0);
    check("r_turn", your_turn, 1);
    check("r_hash", hash, 0);
    check("r_found", match_found, 0);
    check("r_pw", password_byte, 0);
    check("r_blink", blinky_led, 0);
    check("start_all_bits", bad_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
